// File: rtl/rhs_axil_cfg_regs.sv
// rhs_axil_cfg_regs
//   AXI4-Lite slave register file for the RHS configuration bus. Holds the
//   stimulation/acquisition parameters as static outputs, turns 0->1 edges on
//   CTRL[1..3] into one-cycle command strobes, and locks the parameter
//   registers while stimulation is enabled (CTRL[3]).
//
// Ports
//   rhs_aclk, rhs_areset   clock, synchronous active-high reset
//   s_axi_aw* / s_axi_w*   write address / write data channels
//   s_axi_b*               write response channel
//   s_axi_ar* / s_axi_r*   read address / read data channels
//   stim_busy              controller status, read live at CTRL[31]
//   cfg_*                  register contents, driven straight from storage
//   cmd_*                  one-cycle command strobes
//
// Map: 0x00 CTRL, 0x04 STIM_MAG, 0x08 PKT_LEN, 0x0C ZCHECK, 0x10 STIM_CH,
//      0x14 PULSE_W, 0x18 IPD, 0x1C NUM_PULSE. 0x20 and above is unmapped.
module rhs_axil_cfg_regs #(
   parameter int unsigned ADDR_WIDTH  = 6,
   parameter logic [7:0]  PKT_LEN_RST = 8'd1
) (
   input  logic                  rhs_aclk,
   input  logic                  rhs_areset,
   input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
   input  logic                  s_axi_awvalid,
   output logic                  s_axi_awready,
   input  logic [31:0]           s_axi_wdata,
   input  logic [3:0]            s_axi_wstrb,
   input  logic                  s_axi_wvalid,
   output logic                  s_axi_wready,
   output logic [1:0]            s_axi_bresp,
   output logic                  s_axi_bvalid,
   input  logic                  s_axi_bready,
   input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
   input  logic                  s_axi_arvalid,
   output logic                  s_axi_arready,
   output logic [31:0]           s_axi_rdata,
   output logic [1:0]            s_axi_rresp,
   output logic                  s_axi_rvalid,
   input  logic                  s_axi_rready,
   input  logic                  stim_busy,
   output logic                  cfg_run,
   output logic                  cfg_stim_en,
   output logic                  cfg_loopback,
   output logic                  cmd_init,
   output logic                  cmd_mag_set,
   output logic                  cmd_stim,
   output logic [31:0]           cfg_stim_mag,
   output logic [7:0]            cfg_pkt_len,
   output logic [7:0]            cfg_zc_cycle,
   output logic [1:0]            cfg_zc_scale,
   output logic [4:0]            cfg_ch_pos,
   output logic [4:0]            cfg_ch_neg,
   output logic                  cfg_monopolar,
   output logic [15:0]           cfg_pulse_width,
   output logic [15:0]           cfg_ipd,
   output logic [7:0]            cfg_num_pulse
);

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // Channel state
   logic                  rdy_en_q;
   logic                  aw_held_q;
   logic                  w_held_q;
   logic [ADDR_WIDTH-1:0] aw_addr_q;
   logic [31:0]           w_data_q;
   logic [3:0]            w_strb_q;
   logic                  bvalid_q;
   logic [1:0]            bresp_q;
   logic                  rvalid_q;
   logic [31:0]           rdata_q;
   logic [1:0]            rresp_q;

   // Register storage (CTRL bit 4 is never set)
   logic [5:0]  ctrl_q;
   logic [31:0] stim_mag_q;
   logic [7:0]  pkt_len_q;
   logic [7:0]  zc_cycle_q;
   logic [1:0]  zc_scale_q;
   logic [4:0]  ch_pos_q;
   logic [4:0]  ch_neg_q;
   logic        mono_q;
   logic [15:0] pw_q;
   logic [15:0] ipd_q;
   logic [7:0]  npulse_q;

   logic cmd_init_q, cmd_mag_q, cmd_stim_q;
   logic cmd_init_d, cmd_mag_d, cmd_stim_d;

   logic        aw_hs, w_hs, b_hs, ar_hs, r_hs;
   logic        wr_go, wr_mapped, wr_ok, ctrl_wr;
   logic [2:0]  wr_idx, rd_idx;
   logic        rd_mapped;
   logic [31:0] wr_mask, wr_img;
   logic [31:0] reg_img [8];

   // Address bits [1:0] carry no information for word registers.
   logic unused_addr_lsb;
   assign unused_addr_lsb = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0], aw_addr_q[1:0]};

   assign s_axi_awready = rdy_en_q & ~aw_held_q & ~bvalid_q;
   assign s_axi_wready  = rdy_en_q & ~w_held_q & ~bvalid_q;
   assign s_axi_arready = rdy_en_q & ~rvalid_q;

   assign aw_hs = s_axi_awvalid & s_axi_awready;
   assign w_hs  = s_axi_wvalid & s_axi_wready;
   assign b_hs  = bvalid_q & s_axi_bready;
   assign ar_hs = s_axi_arvalid & s_axi_arready;
   assign r_hs  = rvalid_q & s_axi_rready;

   always_comb begin
      reg_img[0] = {stim_busy, 25'd0, ctrl_q};
      reg_img[1] = stim_mag_q;
      reg_img[2] = {24'd0, pkt_len_q};
      reg_img[3] = {22'd0, zc_scale_q, zc_cycle_q};
      reg_img[4] = {21'd0, mono_q, ch_neg_q, ch_pos_q};
      reg_img[5] = {16'd0, pw_q};
      reg_img[6] = {16'd0, ipd_q};
      reg_img[7] = {24'd0, npulse_q};
   end

   // Commit happens in the cycle where both halves of the write are held.
   always_comb begin
      wr_go     = aw_held_q & w_held_q;
      wr_idx    = aw_addr_q[4:2];
      wr_mapped = (aw_addr_q[ADDR_WIDTH-1:5] == '0);
      wr_ok     = wr_go & wr_mapped & ~(ctrl_q[3] & (wr_idx != 3'd0));
      wr_mask   = {{8{w_strb_q[3]}}, {8{w_strb_q[2]}}, {8{w_strb_q[1]}}, {8{w_strb_q[0]}}};
      wr_img    = (reg_img[wr_idx] & ~wr_mask) | (w_data_q & wr_mask);
      ctrl_wr   = wr_ok & (wr_idx == 3'd0);
      // Strobes fire only on a 0->1 edge of the stored bit.
      cmd_init_d = ctrl_wr & wr_img[1] & ~ctrl_q[1];
      cmd_mag_d  = ctrl_wr & wr_img[2] & ~ctrl_q[2];
      cmd_stim_d = ctrl_wr & wr_img[3] & ~ctrl_q[3];
      rd_idx    = s_axi_araddr[4:2];
      rd_mapped = (s_axi_araddr[ADDR_WIDTH-1:5] == '0);
   end

   always_ff @(posedge rhs_aclk) begin
      if (rhs_areset) begin
         rdy_en_q   <= 1'b0;
         aw_held_q  <= 1'b0;
         w_held_q   <= 1'b0;
         aw_addr_q  <= '0;
         w_data_q   <= '0;
         w_strb_q   <= '0;
         bvalid_q   <= 1'b0;
         bresp_q    <= RESP_OKAY;
         rvalid_q   <= 1'b0;
         rdata_q    <= '0;
         rresp_q    <= RESP_OKAY;
         cmd_init_q <= 1'b0;
         cmd_mag_q  <= 1'b0;
         cmd_stim_q <= 1'b0;
         ctrl_q     <= '0;
         stim_mag_q <= '0;
         pkt_len_q  <= PKT_LEN_RST;
         zc_cycle_q <= '0;
         zc_scale_q <= '0;
         ch_pos_q   <= '0;
         ch_neg_q   <= '0;
         mono_q     <= 1'b0;
         pw_q       <= '0;
         ipd_q      <= '0;
         npulse_q   <= '0;
      end else begin
         rdy_en_q   <= 1'b1;
         cmd_init_q <= cmd_init_d;
         cmd_mag_q  <= cmd_mag_d;
         cmd_stim_q <= cmd_stim_d;

         if (aw_hs) begin
            aw_held_q <= 1'b1;
            aw_addr_q <= s_axi_awaddr;
         end
         if (w_hs) begin
            w_held_q <= 1'b1;
            w_data_q <= s_axi_wdata;
            w_strb_q <= s_axi_wstrb;
         end

         if (wr_go) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            bvalid_q  <= 1'b1;
            bresp_q   <= wr_ok ? RESP_OKAY : RESP_SLVERR;
         end else if (b_hs) begin
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
         end

         if (wr_ok) begin
            unique case (wr_idx)
               3'd0: ctrl_q     <= {wr_img[5], 1'b0, wr_img[3:0]};
               3'd1: stim_mag_q <= wr_img;
               3'd2: pkt_len_q  <= wr_img[7:0];
               3'd3: begin
                  zc_cycle_q <= wr_img[7:0];
                  zc_scale_q <= wr_img[9:8];
               end
               3'd4: begin
                  ch_pos_q <= wr_img[4:0];
                  ch_neg_q <= wr_img[9:5];
                  mono_q   <= wr_img[10];
               end
               3'd5: pw_q     <= wr_img[15:0];
               3'd6: ipd_q    <= wr_img[15:0];
               3'd7: npulse_q <= wr_img[7:0];
               default: ;
            endcase
         end

         // Read samples storage before any same-cycle commit lands.
         if (ar_hs) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_mapped ? reg_img[rd_idx] : 32'd0;
            rresp_q  <= rd_mapped ? RESP_OKAY : RESP_SLVERR;
         end else if (r_hs) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
         end
      end
   end

   assign s_axi_bvalid = bvalid_q;
   assign s_axi_bresp  = bresp_q;
   assign s_axi_rvalid = rvalid_q;
   assign s_axi_rdata  = rdata_q;
   assign s_axi_rresp  = rresp_q;

   assign cfg_run         = ctrl_q[0];
   assign cfg_stim_en     = ctrl_q[3];
   assign cfg_loopback    = ctrl_q[5];
   assign cmd_init        = cmd_init_q;
   assign cmd_mag_set     = cmd_mag_q;
   assign cmd_stim        = cmd_stim_q;
   assign cfg_stim_mag    = stim_mag_q;
   assign cfg_pkt_len     = pkt_len_q;
   assign cfg_zc_cycle    = zc_cycle_q;
   assign cfg_zc_scale    = zc_scale_q;
   assign cfg_ch_pos      = ch_pos_q;
   assign cfg_ch_neg      = ch_neg_q;
   assign cfg_monopolar   = mono_q;
   assign cfg_pulse_width = pw_q;
   assign cfg_ipd         = ipd_q;
   assign cfg_num_pulse   = npulse_q;

endmodule

// File: tb/tb_rhs_axil_cfg_regs.sv
module tb_rhs_axil_cfg_regs;

   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;

   logic        rhs_aclk = 1'b0;
   logic        rhs_areset;
   logic [5:0]  s_axi_awaddr;
   logic        s_axi_awvalid, s_axi_awready;
   logic [31:0] s_axi_wdata;
   logic [3:0]  s_axi_wstrb;
   logic        s_axi_wvalid, s_axi_wready;
   logic [1:0]  s_axi_bresp;
   logic        s_axi_bvalid, s_axi_bready;
   logic [5:0]  s_axi_araddr;
   logic        s_axi_arvalid, s_axi_arready;
   logic [31:0] s_axi_rdata;
   logic [1:0]  s_axi_rresp;
   logic        s_axi_rvalid, s_axi_rready;
   logic        stim_busy;
   logic        cfg_run, cfg_stim_en, cfg_loopback;
   logic        cmd_init, cmd_mag_set, cmd_stim;
   logic [31:0] cfg_stim_mag;
   logic [7:0]  cfg_pkt_len, cfg_zc_cycle;
   logic [1:0]  cfg_zc_scale;
   logic [4:0]  cfg_ch_pos, cfg_ch_neg;
   logic        cfg_monopolar;
   logic [15:0] cfg_pulse_width, cfg_ipd;
   logic [7:0]  cfg_num_pulse;

   int n_checks = 0;
   int n_pass   = 0;
   int cnt_init = 0;
   int cnt_mag  = 0;
   int cnt_stim = 0;

   logic [31:0] exp_data_q [$];
   logic [1:0]  exp_resp_q [$];

   rhs_axil_cfg_regs #(.ADDR_WIDTH(6), .PKT_LEN_RST(8'd1)) dut (
      .rhs_aclk        (rhs_aclk),
      .rhs_areset      (rhs_areset),
      .s_axi_awaddr    (s_axi_awaddr),
      .s_axi_awvalid   (s_axi_awvalid),
      .s_axi_awready   (s_axi_awready),
      .s_axi_wdata     (s_axi_wdata),
      .s_axi_wstrb     (s_axi_wstrb),
      .s_axi_wvalid    (s_axi_wvalid),
      .s_axi_wready    (s_axi_wready),
      .s_axi_bresp     (s_axi_bresp),
      .s_axi_bvalid    (s_axi_bvalid),
      .s_axi_bready    (s_axi_bready),
      .s_axi_araddr    (s_axi_araddr),
      .s_axi_arvalid   (s_axi_arvalid),
      .s_axi_arready   (s_axi_arready),
      .s_axi_rdata     (s_axi_rdata),
      .s_axi_rresp     (s_axi_rresp),
      .s_axi_rvalid    (s_axi_rvalid),
      .s_axi_rready    (s_axi_rready),
      .stim_busy       (stim_busy),
      .cfg_run         (cfg_run),
      .cfg_stim_en     (cfg_stim_en),
      .cfg_loopback    (cfg_loopback),
      .cmd_init        (cmd_init),
      .cmd_mag_set     (cmd_mag_set),
      .cmd_stim        (cmd_stim),
      .cfg_stim_mag    (cfg_stim_mag),
      .cfg_pkt_len     (cfg_pkt_len),
      .cfg_zc_cycle    (cfg_zc_cycle),
      .cfg_zc_scale    (cfg_zc_scale),
      .cfg_ch_pos      (cfg_ch_pos),
      .cfg_ch_neg      (cfg_ch_neg),
      .cfg_monopolar   (cfg_monopolar),
      .cfg_pulse_width (cfg_pulse_width),
      .cfg_ipd         (cfg_ipd),
      .cfg_num_pulse   (cfg_num_pulse)
   );

   always #5 rhs_aclk = ~rhs_aclk;

   // Strobe-cycle counters, sampled away from the active edge.
   always @(negedge rhs_aclk) begin
      if (cmd_init === 1'b1)    cnt_init <= cnt_init + 1;
      if (cmd_mag_set === 1'b1) cnt_mag  <= cnt_mag + 1;
      if (cmd_stim === 1'b1)    cnt_stim <= cnt_stim + 1;
   end

   task automatic do_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
      int  n;
      logic aw_hs, w_hs;
      @(negedge rhs_aclk);
      s_axi_awaddr = a; s_axi_awvalid = 1'b1;
      s_axi_wdata = d; s_axi_wstrb = s; s_axi_wvalid = 1'b1;
      s_axi_bready = 1'b1;
      n = 0;
      while ((s_axi_awvalid || s_axi_wvalid) && n < 50) begin
         aw_hs = s_axi_awvalid && s_axi_awready;
         w_hs  = s_axi_wvalid && s_axi_wready;
         @(negedge rhs_aclk);
         if (aw_hs) s_axi_awvalid = 1'b0;
         if (w_hs)  s_axi_wvalid = 1'b0;
         n++;
      end
      while (s_axi_bvalid !== 1'b1 && n < 50) begin
         @(negedge rhs_aclk);
         n++;
      end
      resp = s_axi_bresp;
      if (n >= 50) begin
         n_checks++;
         $display("FAIL write_timeout addr=%h bvalid=%b expected bvalid=1", a, s_axi_bvalid);
         s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
         resp = 2'bxx;
      end
      @(negedge rhs_aclk);
   endtask

   task automatic do_read(input logic [5:0] a, output logic [31:0] data, output logic [1:0] resp);
      int n;
      logic ar_hs;
      @(negedge rhs_aclk);
      s_axi_araddr = a; s_axi_arvalid = 1'b1; s_axi_rready = 1'b1;
      n = 0;
      while (s_axi_arvalid && n < 50) begin
         ar_hs = s_axi_arready;
         @(negedge rhs_aclk);
         if (ar_hs) s_axi_arvalid = 1'b0;
         n++;
      end
      while (s_axi_rvalid !== 1'b1 && n < 50) begin
         @(negedge rhs_aclk);
         n++;
      end
      data = s_axi_rdata;
      resp = s_axi_rresp;
      if (n >= 50) begin
         n_checks++;
         $display("FAIL read_timeout addr=%h rvalid=%b expected rvalid=1", a, s_axi_rvalid);
         s_axi_arvalid = 1'b0;
         data = 'x; resp = 2'bxx;
      end
      @(negedge rhs_aclk);
   endtask

   // Write with an expected response routed through the scoreboard.
   task automatic test_write_resp(input string name, input logic [5:0] a, input logic [31:0] d,
                                  input logic [3:0] s, input logic [1:0] exp);
      logic [1:0] resp, e;
      exp_resp_q.push_back(exp);
      do_write(a, d, s, resp);
      e = exp_resp_q.pop_front();
      n_checks++;
      if (resp !== e) $display("FAIL %s bresp got=%b exp=%b", name, resp, e);
      else n_pass++;
   endtask

   task automatic test_read_exp(input string name, input logic [5:0] a, input logic [31:0] exp_d,
                                input logic [1:0] exp_r);
      logic [31:0] d, ed;
      logic [1:0]  r, er;
      exp_data_q.push_back(exp_d);
      exp_resp_q.push_back(exp_r);
      do_read(a, d, r);
      ed = exp_data_q.pop_front();
      er = exp_resp_q.pop_front();
      n_checks++;
      if (d !== ed || r !== er)
         $display("FAIL %s rdata/rresp got=%h/%b exp=%h/%b", name, d, r, ed, er);
      else n_pass++;
   endtask

   task automatic test_reset();
      logic [31:0] defaults [8];
      rhs_areset = 1'b1;
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
      s_axi_bready = 1'b1; s_axi_rready = 1'b1; stim_busy = 1'b0;
      s_axi_awaddr = '0; s_axi_araddr = '0; s_axi_wdata = '0; s_axi_wstrb = '0;
      repeat (3) @(negedge rhs_aclk);
      rhs_areset = 1'b0;
      @(negedge rhs_aclk);
      n_checks++;
      if ({s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid} !== 5'b11100)
         $display("FAIL reset_handshake got=%b exp=11100",
                  {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid});
      else n_pass++;
      n_checks++;
      if (s_axi_rdata !== 32'd0 || s_axi_bresp !== OKAY || s_axi_rresp !== OKAY || cfg_pkt_len !== 8'd1)
         $display("FAIL reset_outputs rdata=%h bresp=%b rresp=%b pkt_len=%h exp 0/0/0/01",
                  s_axi_rdata, s_axi_bresp, s_axi_rresp, cfg_pkt_len);
      else n_pass++;
      for (int i = 0; i < 8; i++) defaults[i] = (i == 2) ? 32'd1 : 32'd0;
      for (int i = 0; i < 8; i++) test_read_exp("reset_default", 6'(i * 4), defaults[i], OKAY);
   endtask

   task automatic test_busy();
      stim_busy = 1'b1;
      test_read_exp("busy_bit", 6'h00, 32'h8000_0000, OKAY);
      stim_busy = 1'b0;
      test_read_exp("busy_clear", 6'h00, 32'h0, OKAY);
   endtask

   task automatic test_masking();
      test_write_resp("stim_mag_wr", 6'h04, 32'h80FF80FF, 4'hF, OKAY);
      test_read_exp("stim_mag_rd", 6'h04, 32'h80FF80FF, OKAY);
      test_write_resp("stim_ch_wr", 6'h10, 32'hFFFFFFFF, 4'hF, OKAY);
      test_read_exp("stim_ch_rd", 6'h10, 32'h000007FF, OKAY);
      n_checks++;
      if (cfg_ch_pos !== 5'd31 || cfg_ch_neg !== 5'd31 || cfg_monopolar !== 1'b1)
         $display("FAIL stim_ch_out pos=%0d neg=%0d mono=%b exp 31/31/1", cfg_ch_pos, cfg_ch_neg, cfg_monopolar);
      else n_pass++;
      test_write_resp("zcheck_wr", 6'h0C, 32'h00000304, 4'hF, OKAY);
      n_checks++;
      if (cfg_zc_scale !== 2'd3 || cfg_zc_cycle !== 8'd4)
         $display("FAIL zcheck_out scale=%0d cycle=%0d exp 3/4", cfg_zc_scale, cfg_zc_cycle);
      else n_pass++;
      test_write_resp("pkt_len_wr", 6'h08, 32'hABCD_1240, 4'hF, OKAY);
      test_read_exp("pkt_len_rd", 6'h08, 32'h00000040, OKAY);
   endtask

   task automatic test_wstrb();
      test_write_resp("wstrb_byte1", 6'h04, 32'h12345678, 4'b0010, OKAY);
      test_read_exp("wstrb_byte1_rd", 6'h04, 32'h80FF56FF, OKAY);
      test_write_resp("wstrb_zero", 6'h04, 32'hFFFFFFFF, 4'b0000, OKAY);
      test_read_exp("wstrb_zero_rd", 6'h04, 32'h80FF56FF, OKAY);
   endtask

   task automatic test_strobes();
      int bi, bm, bs;
      bi = cnt_init; bm = cnt_mag; bs = cnt_stim;
      test_write_resp("ctrl_23", 6'h00, 32'h23, 4'hF, OKAY);
      repeat (2) @(negedge rhs_aclk);
      n_checks++;
      if (cnt_init - bi !== 1 || cnt_mag - bm !== 0 || cnt_stim - bs !== 0 || cfg_loopback !== 1'b1 || cfg_run !== 1'b1)
         $display("FAIL strobe_init init=%0d mag=%0d stim=%0d lb=%b run=%b exp 1/0/0/1/1",
                  cnt_init - bi, cnt_mag - bm, cnt_stim - bs, cfg_loopback, cfg_run);
      else n_pass++;
      bi = cnt_init;
      test_write_resp("ctrl_23_again", 6'h00, 32'h23, 4'hF, OKAY);
      repeat (2) @(negedge rhs_aclk);
      n_checks++;
      if (cnt_init - bi !== 0)
         $display("FAIL strobe_rewrite init=%0d exp 0", cnt_init - bi);
      else n_pass++;
      test_write_resp("ctrl_00", 6'h00, 32'h00, 4'hF, OKAY);
      bi = cnt_init; bs = cnt_stim;
      test_write_resp("ctrl_29", 6'h00, 32'h29, 4'hF, OKAY);
      repeat (2) @(negedge rhs_aclk);
      n_checks++;
      if (cnt_stim - bs !== 1 || cnt_init - bi !== 0 || cfg_stim_en !== 1'b1)
         $display("FAIL strobe_stim stim=%0d init=%0d stim_en=%b exp 1/0/1", cnt_stim - bs, cnt_init - bi, cfg_stim_en);
      else n_pass++;
      bm = cnt_mag;
      test_write_resp("ctrl_2d", 6'h00, 32'h2D, 4'hF, OKAY);
      repeat (2) @(negedge rhs_aclk);
      n_checks++;
      if (cnt_mag - bm !== 1) $display("FAIL strobe_mag mag=%0d exp 1", cnt_mag - bm);
      else n_pass++;
      test_write_resp("ctrl_29_b", 6'h00, 32'h29, 4'hF, OKAY);
   endtask

   task automatic test_lock();
      test_write_resp("locked_ipd", 6'h18, 32'h10, 4'hF, SLVERR);
      n_checks++;
      if (cfg_ipd !== 16'd0) $display("FAIL locked_ipd_out got=%0d exp 0", cfg_ipd);
      else n_pass++;
      test_write_resp("unlock_ctrl", 6'h00, 32'h0, 4'hF, OKAY);
      test_write_resp("unlocked_ipd", 6'h18, 32'h10, 4'hF, OKAY);
      n_checks++;
      if (cfg_ipd !== 16'd16) $display("FAIL unlocked_ipd_out got=%0d exp 16", cfg_ipd);
      else n_pass++;
   endtask

   task automatic test_handshake_order();
      int n;
      logic [1:0] b0;
      @(negedge rhs_aclk);
      s_axi_bready = 1'b0;
      s_axi_wdata = 32'h5A; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
      @(negedge rhs_aclk);
      s_axi_wvalid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (s_axi_wready !== 1'b0 || s_axi_bvalid !== 1'b0 || s_axi_awready !== 1'b1)
            $display("FAIL w_first_wait wready=%b bvalid=%b awready=%b exp 0/0/1", s_axi_wready, s_axi_bvalid, s_axi_awready);
         else n_pass++;
         @(negedge rhs_aclk);
      end
      s_axi_awaddr = 6'h1C; s_axi_awvalid = 1'b1;
      @(negedge rhs_aclk);
      s_axi_awvalid = 1'b0;
      n = 0;
      while (s_axi_bvalid !== 1'b1 && n < 20) begin
         @(negedge rhs_aclk);
         n++;
      end
      b0 = s_axi_bresp;
      n_checks++;
      if (s_axi_bvalid !== 1'b1 || b0 !== OKAY || cfg_num_pulse !== 8'h5A)
         $display("FAIL order_commit bvalid=%b bresp=%b num_pulse=%h exp 1/00/5a", s_axi_bvalid, b0, cfg_num_pulse);
      else n_pass++;
      for (int i = 0; i < 4; i++) begin
         @(negedge rhs_aclk);
         n_checks++;
         if (s_axi_bvalid !== 1'b1 || s_axi_bresp !== b0 || s_axi_awready !== 1'b0 || s_axi_wready !== 1'b0)
            $display("FAIL b_stall bvalid=%b bresp=%b awready=%b wready=%b exp 1/%b/0/0",
                     s_axi_bvalid, s_axi_bresp, s_axi_awready, s_axi_wready, b0);
         else n_pass++;
      end
      s_axi_bready = 1'b1;
      @(negedge rhs_aclk);
      n_checks++;
      if (s_axi_bvalid !== 1'b0 || s_axi_awready !== 1'b1 || s_axi_wready !== 1'b1 || s_axi_bresp !== OKAY)
         $display("FAIL b_release bvalid=%b awready=%b wready=%b bresp=%b exp 0/1/1/00",
                  s_axi_bvalid, s_axi_awready, s_axi_wready, s_axi_bresp);
      else n_pass++;
      test_read_exp("order_rd", 6'h1C, 32'h5A, OKAY);
   endtask

   task automatic test_errors();
      test_write_resp("unmapped_wr", 6'h24, 32'hFFFFFFFF, 4'hF, SLVERR);
      test_read_exp("unmapped_rd", 6'h24, 32'h0, SLVERR);
      test_read_exp("unmapped_no_alias", 6'h04, 32'h80FF56FF, OKAY);
   endtask

   task automatic test_back_to_back();
      int hs, last;
      bit gap_ok;
      logic hs_now;
      @(negedge rhs_aclk);
      s_axi_awaddr = 6'h14; s_axi_wdata = 32'h100; s_axi_wstrb = 4'hF;
      s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_bready = 1'b1;
      hs = 0; last = -1; gap_ok = 1'b1;
      for (int i = 0; i < 12; i++) begin
         hs_now = s_axi_awready && s_axi_wready;
         if (hs_now) begin
            if (last >= 0 && i - last != 3) gap_ok = 1'b0;
            last = i;
            hs++;
         end
         @(negedge rhs_aclk);
         if (hs_now) s_axi_wdata = s_axi_wdata + 32'd1;
      end
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
      n_checks++;
      if (hs !== 4 || !gap_ok || cfg_pulse_width !== 16'h103)
         $display("FAIL back_to_back writes=%0d gap_ok=%b pulse_w=%h exp 4/1/0103", hs, gap_ok, cfg_pulse_width);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      int n;
      test_write_resp("pre_rst_ctrl", 6'h00, 32'h01, 4'hF, OKAY);
      @(negedge rhs_aclk);
      s_axi_bready = 1'b0;
      s_axi_awaddr = 6'h1C; s_axi_awvalid = 1'b1;
      s_axi_wdata = 32'h77; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
      @(negedge rhs_aclk);
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
      n = 0;
      while (s_axi_bvalid !== 1'b1 && n < 20) begin
         @(negedge rhs_aclk);
         n++;
      end
      n_checks++;
      if (s_axi_bvalid !== 1'b1) $display("FAIL pre_reset_bvalid got=%b exp 1", s_axi_bvalid);
      else n_pass++;
      rhs_areset = 1'b1;
      @(negedge rhs_aclk);
      n_checks++;
      if (s_axi_bvalid !== 1'b0 || cfg_run !== 1'b0 || cfg_num_pulse !== 8'd0 || cfg_pkt_len !== 8'd1
          || cfg_stim_mag !== 32'd0 || cfg_ipd !== 16'd0 || cfg_pulse_width !== 16'd0 || cfg_ch_pos !== 5'd0)
         $display("FAIL mid_reset bvalid=%b run=%b npulse=%h pkt=%h mag=%h ipd=%h pw=%h pos=%h exp 0/0/00/01/0/0/0/0",
                  s_axi_bvalid, cfg_run, cfg_num_pulse, cfg_pkt_len, cfg_stim_mag, cfg_ipd, cfg_pulse_width, cfg_ch_pos);
      else n_pass++;
      rhs_areset = 1'b0;
      s_axi_bready = 1'b1;
      @(negedge rhs_aclk);
      n_checks++;
      if (s_axi_awready !== 1'b1 || s_axi_wready !== 1'b1 || s_axi_bvalid !== 1'b0)
         $display("FAIL post_reset_ready awready=%b wready=%b bvalid=%b exp 1/1/0", s_axi_awready, s_axi_wready, s_axi_bvalid);
      else n_pass++;
      test_read_exp("post_reset_mag", 6'h04, 32'h0, OKAY);
      test_read_exp("post_reset_pkt", 6'h08, 32'h1, OKAY);
   endtask

   initial begin
      test_reset();
      test_busy();
      test_masking();
      test_wstrb();
      test_strobes();
      test_lock();
      test_handshake_order();
      test_errors();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
